// File: rtl/usb_ep2_pattern_engine.sv
// EP2 user-side engine: buffered loopback, incrementing source, checking sink.
// Keeps rx/tx byte counters and a saturating sink error counter.
module usb_ep2_pattern_engine #(
    parameter int          DEPTH = 16,
    parameter logic [7:0]  SEED  = 8'h00
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [1:0]  i_mode,
    input  logic        i_clear,
    input  logic        i_rx_dval,
    input  logic [7:0]  i_rx_data,
    output logic        o_rx_rdy,
    input  logic        i_tx_afull,
    output logic        o_tx_dval,
    output logic [7:0]  o_tx_data,
    output logic [31:0] o_rx_cnt,
    output logic [31:0] o_tx_cnt,
    output logic [15:0] o_err_cnt,
    output logic        o_synced
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        M_LOOP = 2'd0,
        M_SRC  = 2'd1,
        M_SINK = 2'd2,
        M_IDLE = 2'd3
    } mode_e;

    mode_e          mode_q;
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    count_q;
    logic [7:0]     mem_q [DEPTH];
    logic [7:0]     src_q, exp_q;
    logic           tx_dval_q;
    logic [7:0]     tx_data_q;
    logic [31:0]    rx_cnt_q, tx_cnt_q;
    logic [15:0]    err_cnt_q;
    logic           synced_q;

    logic chg, accept, lb, push, pop, emit;

    assign chg    = mode_e'(i_mode) != mode_q;
    assign accept = i_rx_dval && o_rx_rdy;
    assign lb     = (mode_q == M_LOOP) && !chg;
    assign push   = accept && lb;
    assign pop    = lb && (count_q != '0) && !i_tx_afull;
    assign emit   = (mode_q == M_SRC) && !chg && !i_tx_afull;

    assign o_rx_rdy  = (mode_q != M_LOOP) || (count_q != FULL);
    assign o_tx_dval = tx_dval_q;
    assign o_tx_data = tx_data_q;
    assign o_rx_cnt  = rx_cnt_q;
    assign o_tx_cnt  = tx_cnt_q;
    assign o_err_cnt = err_cnt_q;
    assign o_synced  = synced_q;

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= i_rx_data;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mode_q    <= M_LOOP;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            src_q     <= SEED;
            exp_q     <= 8'h00;
            tx_dval_q <= 1'b0;
            tx_data_q <= 8'h00;
            rx_cnt_q  <= '0;
            tx_cnt_q  <= '0;
            err_cnt_q <= '0;
            synced_q  <= 1'b0;
        end else begin
            if (accept) rx_cnt_q <= rx_cnt_q + 32'd1;
            if (tx_dval_q) tx_cnt_q <= tx_cnt_q + 32'd1;

            // A mode change wins over push, pop and emit on this edge.
            if (chg) begin
                mode_q    <= mode_e'(i_mode);
                wr_ptr_q  <= '0;
                rd_ptr_q  <= '0;
                count_q   <= '0;
                src_q     <= SEED;
                synced_q  <= 1'b0;
                tx_dval_q <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
                unique case ({push, pop})
                    2'b10:   count_q <= count_q + (AW+1)'(1);
                    2'b01:   count_q <= count_q - (AW+1)'(1);
                    default: count_q <= count_q;
                endcase

                tx_dval_q <= pop || emit;
                if (pop) begin
                    tx_data_q <= mem_q[rd_ptr_q];
                end else if (emit) begin
                    tx_data_q <= src_q;
                    src_q     <= src_q + 8'd1;
                end

                if ((mode_q == M_SINK) && accept) begin
                    exp_q <= i_rx_data + 8'd1;
                    if (!synced_q) begin
                        synced_q <= 1'b1;
                    end else if (i_rx_data == exp_q) begin
                        exp_q <= exp_q + 8'd1;
                    end else if (err_cnt_q != 16'hFFFF) begin
                        err_cnt_q <= err_cnt_q + 16'd1;
                    end
                end
            end

            if (i_clear) begin
                rx_cnt_q  <= '0;
                tx_cnt_q  <= '0;
                err_cnt_q <= '0;
                synced_q  <= 1'b0;
                src_q     <= SEED;
            end
        end
    end

endmodule

// File: tb/tb_usb_ep2_pattern_engine.sv
// Directed bench for usb_ep2_pattern_engine (DEPTH 16, SEED 8'hFE).
// Output bytes are logged with cycle stamps and compared to fixed vectors.
module tb_usb_ep2_pattern_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        clear = 1'b0;
    logic        rx_dval = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_rdy;
    logic        tx_afull = 1'b0;
    logic        tx_dval;
    logic [7:0]  tx_data;
    logic [31:0] rx_cnt, tx_cnt;
    logic [15:0] err_cnt;
    logic        synced;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int acc = 0;
    int c0;
    logic [7:0] outq[$];
    int out_cyc[$];

    usb_ep2_pattern_engine #(.DEPTH(16), .SEED(8'hFE)) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_mode     (mode),
        .i_clear    (clear),
        .i_rx_dval  (rx_dval),
        .i_rx_data  (rx_data),
        .o_rx_rdy   (rx_rdy),
        .i_tx_afull (tx_afull),
        .o_tx_dval  (tx_dval),
        .o_tx_data  (tx_data),
        .o_rx_cnt   (rx_cnt),
        .o_tx_cnt   (tx_cnt),
        .o_err_cnt  (err_cnt),
        .o_synced   (synced)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        if (rx_dval && rx_rdy) acc++;
        @(posedge clk);
        #1;
        cyc_n++;
        if (tx_dval) begin
            outq.push_back(tx_data);
            out_cyc.push_back(cyc_n);
        end
    endtask

    task automatic flushq();
        outq.delete();
        out_cyc.delete();
    endtask

    initial begin
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        chk("rst_dval", 32'(tx_dval), 32'd0);
        chk("rst_data", 32'(tx_data), 32'h00);
        chk("rst_rxcnt", rx_cnt, 32'd0);
        chk("rst_txcnt", tx_cnt, 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_sync", 32'(synced), 32'd0);
        chk("rst_rdy", 32'(rx_rdy), 32'd1);

        // Loopback ordering / latency
        flushq();
        c0 = cyc_n;
        for (int i = 0; i < 32; i++) begin
            rx_dval = 1'b1;
            rx_data = 8'(8'h10 + i);
            cyc();
        end
        rx_dval = 1'b0;
        repeat (4) cyc();
        chk("lb_n", 32'(outq.size()), 32'd32);
        for (int i = 0; i < 32 && i < outq.size(); i++)
            chk($sformatf("lb_d%0d", i), 32'(outq[i]), 32'(8'h10 + i));
        if (outq.size() == 32) begin
            chk("lb_lat", 32'(out_cyc[0]), 32'(c0 + 2));
            chk("lb_tput", 32'(out_cyc[31] - out_cyc[0]), 32'd31);
        end
        chk("lb_rxcnt", rx_cnt, 32'd32);
        chk("lb_txcnt", tx_cnt, 32'd32);

        // Backpressure / full
        flushq();
        tx_afull = 1'b1;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            rx_dval = 1'b1;
            rx_data = 8'(8'h40 + i);
            cyc();
        end
        chk("bp_acc", 32'(acc), 32'd16);
        chk("bp_rdy", 32'(rx_rdy), 32'd0);
        chk("bp_none", 32'(outq.size()), 32'd0);
        rx_dval = 1'b0;
        tx_afull = 1'b0;
        repeat (20) cyc();
        chk("bp_n", 32'(outq.size()), 32'd16);
        for (int i = 0; i < 16 && i < outq.size(); i++)
            chk($sformatf("bp_d%0d", i), 32'(outq[i]), 32'(8'h40 + i));
        chk("bp_rxcnt", rx_cnt, 32'd48);

        // Mode change with 5 buffered bytes, then source wrap
        tx_afull = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rx_dval = 1'b1;
            rx_data = 8'(8'h80 + i);
            cyc();
        end
        rx_dval = 1'b0;
        flushq();
        mode = 2'd1;
        tx_afull = 1'b0;
        cyc();
        chk("mc_dval", 32'(tx_dval), 32'd0);
        repeat (4) cyc();
        tx_afull = 1'b1;
        cyc();
        tx_afull = 1'b0;
        repeat (3) cyc();
        chk("src_n", 32'(outq.size()), 32'd7);
        if (outq.size() == 7) begin
            chk("src_0", 32'(outq[0]), 32'hFE);
            chk("src_1", 32'(outq[1]), 32'hFF);
            chk("src_2", 32'(outq[2]), 32'h00);
            chk("src_3", 32'(outq[3]), 32'h01);
            chk("src_4", 32'(outq[4]), 32'h02);
            chk("src_6", 32'(outq[6]), 32'h04);
            chk("src_gap", 32'(out_cyc[4] - out_cyc[3]), 32'd2);
            chk("src_tput", 32'(out_cyc[3] - out_cyc[0]), 32'd3);
        end

        // Sink checking
        mode = 2'd2;
        cyc();
        chk("snk_sync0", 32'(synced), 32'd0);
        rx_dval = 1'b1;
        rx_data = 8'h05;
        cyc();
        chk("snk_sync1", 32'(synced), 32'd1);
        rx_data = 8'h06; cyc();
        rx_data = 8'h07; cyc();
        rx_data = 8'h09; cyc();
        chk("snk_err1", 32'(err_cnt), 32'd1);
        rx_data = 8'h0A; cyc();
        rx_dval = 1'b0;
        cyc();
        chk("snk_err", 32'(err_cnt), 32'd1);
        chk("snk_sync", 32'(synced), 32'd1);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("clr_err", 32'(err_cnt), 32'd0);
        chk("clr_sync", 32'(synced), 32'd0);
        rx_dval = 1'b1;
        rx_data = 8'h33;
        repeat (70000) cyc();
        chk("snk_sat", 32'(err_cnt), 32'hFFFF);

        // Clear coincident with accept
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("clr_rxcnt", rx_cnt, 32'd0);
        chk("clr_errcnt", 32'(err_cnt), 32'd0);
        cyc();
        chk("clr_rxinc", rx_cnt, 32'd1);

        // Reset mid-stream in loopback
        mode = 2'd0;
        rx_data = 8'h55;
        repeat (4) cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("amr_rxcnt", rx_cnt, 32'd0);
        chk("amr_txcnt", tx_cnt, 32'd0);
        chk("amr_dval", 32'(tx_dval), 32'd0);
        chk("amr_rdy", 32'(rx_rdy), 32'd1);
        rx_dval = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
